// File: rtl/bpu_pkg.sv
// Shared constants and helpers for the branch target buffer and its return stack.
package bpu_pkg;

    localparam int XLEN = 32;
    localparam int TARGET_W = XLEN;
    localparam int VALID_W = 1;
    localparam logic [XLEN-1:0] INSN_BYTES = 32'd4;

    typedef enum logic [2:0] {
        TR_NONE,
        TR_INC,
        TR_DEC,
        TR_ALLOC,
        TR_INVAL
    } train_e;

    // Counter value at which the MSB turns on: weakly taken, used for fresh entries.
    function automatic int cnt_thresh(input int w);
        return 1 << (w - 1);
    endfunction

    function automatic int cnt_max(input int w);
        return (1 << w) - 1;
    endfunction

    function automatic logic [XLEN-1:0] next_pc(
        input logic            is_branch,
        input logic            taken,
        input logic [XLEN-1:0] target,
        input logic [XLEN-1:0] pc
    );
        return (is_branch && taken) ? target : pc + INSN_BYTES;
    endfunction

endpackage

// File: rtl/bpu_ras.sv
// Circular return address stack; overflow overwrites the oldest slot, underflow wraps.
module bpu_ras
    import bpu_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = XLEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] top
);

    localparam int PW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     ptr_dec;

    assign ptr_dec = ptr - PW'(1);
    assign top     = mem[ptr_dec];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (push && !pop) begin
            ptr <= ptr + PW'(1);
        end else if (pop && !push) begin
            ptr <= ptr_dec;
        end
    end

    // A simultaneous pop and push replaces the top slot in place.
    always_ff @(posedge clk) begin
        if (push) begin
            if (pop) begin
                mem[ptr_dec] <= data;
            end else begin
                mem[ptr] <= data;
            end
        end
    end

endmodule

// File: rtl/bpu_btb.sv
// Tagged BTB with saturating direction counters, mispredict redirect and wrong-path kill.
// Defining BPU_RAS_EN adds a return address stack and a per-entry ret bit.
module bpu_btb
    import bpu_pkg::*;
#(
    parameter int ENTRIES   = 64,
    parameter int TAG_W     = 8,
    parameter int CNT_W     = 2,
    parameter int RAS_DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] if_pc_i,
    output logic        if_pred_taken_o,
    output logic [31:0] if_pred_target_o,
    input  logic        id_valid_i,
    input  logic [31:0] id_pc_i,
    input  logic        id_is_branch_i,
    input  logic        id_taken_i,
    input  logic [31:0] id_target_i,
    input  logic        id_pred_taken_i,
    input  logic [31:0] id_pred_target_i,
    input  logic        id_is_call_i,
    input  logic        id_is_ret_i,
    output logic        flush_o,
    output logic [31:0] flush_pc_o
);

    localparam int IW = $clog2(ENTRIES);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(cnt_thresh(CNT_W));
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(cnt_max(CNT_W));

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
        return (c == '0) ? c : c - CNT_W'(1);
    endfunction

    logic [VALID_W-1:0]  entry_valid  [ENTRIES];
    logic [CNT_W-1:0]    entry_cnt    [ENTRIES];
    logic [TAG_W-1:0]    entry_tag    [ENTRIES];
    logic [TARGET_W-1:0] entry_target [ENTRIES];

    logic             kill_q;
    logic [IW-1:0]    if_idx;
    logic [IW-1:0]    id_idx;
    logic [TAG_W-1:0] if_tag;
    logic [TAG_W-1:0] id_tag;
    logic             if_hit;
    logic             id_hit;
    logic             act;
    logic             mp;
    train_e           train;

    assign if_idx = if_pc_i[IW+1:2];
    assign if_tag = if_pc_i[IW+1+TAG_W:IW+2];
    assign id_idx = id_pc_i[IW+1:2];
    assign id_tag = id_pc_i[IW+1+TAG_W:IW+2];

    assign if_hit = entry_valid[if_idx][0] && (entry_tag[if_idx] == if_tag);
    assign id_hit = entry_valid[id_idx][0] && (entry_tag[id_idx] == id_tag);

    assign if_pred_taken_o = if_hit && entry_cnt[if_idx][CNT_W-1];

`ifdef BPU_RAS_EN
    logic             entry_ret [ENTRIES];
    logic [XLEN-1:0]  ras_top;

    bpu_ras #(
        .DEPTH  (RAS_DEPTH),
        .DATA_W (XLEN)
    ) u_ras (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (act && id_is_call_i),
        .pop   (act && id_is_ret_i),
        .data  (id_pc_i + INSN_BYTES),
        .top   (ras_top)
    );

    assign if_pred_target_o = entry_ret[if_idx] ? ras_top : entry_target[if_idx];

    always_ff @(posedge clk_i) begin
        if (train == TR_ALLOC) begin
            entry_ret[id_idx] <= id_is_ret_i;
        end
    end
`else
    logic unused_ras;

    assign unused_ras       = ^{id_is_call_i, id_is_ret_i};
    assign if_pred_target_o = entry_target[if_idx];
`endif

    logic unused_pc;
    assign unused_pc = ^if_pc_i;

    // The instruction right after a redirect is on the wrong path and is dropped.
    assign act = id_valid_i && !kill_q;

    always_comb begin
        mp = 1'b0;
        if (id_is_branch_i) begin
            mp = (id_pred_taken_i != id_taken_i) ||
                 (id_pred_taken_i && id_taken_i && (id_pred_target_i != id_target_i));
        end else begin
            mp = id_pred_taken_i;
        end
    end

    assign flush_o    = act && mp;
    assign flush_pc_o = next_pc(id_is_branch_i, id_taken_i, id_target_i, id_pc_i);

    always_comb begin
        train = TR_NONE;
        if (act) begin
            if (id_is_branch_i) begin
                if (id_taken_i) begin
                    train = id_hit ? TR_INC : TR_ALLOC;
                end else if (id_hit) begin
                    train = TR_DEC;
                end
            end else if (id_hit) begin
                train = TR_INVAL;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            kill_q <= 1'b0;
            for (int i = 0; i < ENTRIES; i++) begin
                entry_valid[i] <= '0;
                entry_cnt[i]   <= '0;
            end
        end else begin
            kill_q <= flush_o;
            case (train)
                TR_INC: entry_cnt[id_idx] <= sat_inc(entry_cnt[id_idx]);
                TR_DEC: entry_cnt[id_idx] <= sat_dec(entry_cnt[id_idx]);
                TR_ALLOC: begin
                    entry_valid[id_idx] <= 1'b1;
                    entry_cnt[id_idx]   <= CNT_INIT;
                end
                TR_INVAL: entry_valid[id_idx] <= 1'b0;
                default: ;
            endcase
        end
    end

    // Tag and target storage carry no reset; the valid bit qualifies them.
    always_ff @(posedge clk_i) begin
        if (train == TR_ALLOC) begin
            entry_tag[id_idx] <= id_tag;
        end
        if ((train == TR_ALLOC) || (train == TR_INC)) begin
            entry_target[id_idx] <= id_target_i;
        end
    end

endmodule

// File: doc/bpu_btb.md
# bpu_btb

Parametrised tagged branch target buffer with saturating direction counters and an optional return address stack. It sits between IF and ID: IF gets a same-cycle combinational taken/target prediction for the fetch PC, and ID reports each resolved instruction back. The block then detects mispredictions, raises a redirect with the correct PC, and trains the table. Width, table depth, tag width and counter width are all parameters. Tag matching, a valid bit per entry and wrong-path kill are part of the base block.

## Interface
Parameters:
- ENTRIES, 64, table depth; must be a power of two, minimum 2
- TAG_W, 8, tag bits stored per entry
- CNT_W, 2, saturating counter width; predicts taken when the counter MSB is 1
- RAS_DEPTH, 8, return stack depth; power of two; used only with BPU_RAS_EN

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- if_pc_i  in  32  fetch PC
- if_pred_taken_o  out  1  predict taken
- if_pred_target_o  out  32  predicted target
- id_valid_i  in  1  ID holds a resolved instruction this cycle
- id_pc_i  in  32  PC of the ID instruction
- id_is_branch_i  in  1  instruction is a branch or jump
- id_taken_i  in  1  actual direction
- id_target_i  in  32  actual target
- id_pred_taken_i  in  1  prediction made for this instruction, carried down from IF
- id_pred_target_i  in  32  target predicted for this instruction
- id_is_call_i  in  1  call (link) instruction; ignored unless BPU_RAS_EN
- id_is_ret_i  in  1  return instruction; ignored unless BPU_RAS_EN
- flush_o  out  1  redirect fetch
- flush_pc_o  out  32  redirect PC

## Operation
- IW = log2(ENTRIES).
- idx = pc[IW+1:2]; tag = pc[IW+1+TAG_W:IW+2].
- Each entry holds: valid, tag, cnt[CNT_W], target[32], plus a ret bit when BPU_RAS_EN is defined.
- Predict, combinational:
  - hit = valid && tag match.
  - if_pred_taken_o = hit && cnt MSB.
  - if_pred_target_o = stored target, or RAS top when the entry's ret bit is set.
  - When if_pred_taken_o = 0, if_pred_target_o is don't-care.
- An update is active when act = id_valid_i && !kill_q.
- Mispredict (mp), evaluated only when act:
  - Branch: id_pred_taken_i != id_taken_i, or (both taken and id_pred_target_i != id_target_i).
  - Non-branch: id_pred_taken_i.
- Outputs:
  - flush_o = act && mp.
  - flush_pc_o = id_target_i when (branch && taken), else id_pc_i+4. Arithmetic is 32-bit and wraps.
- Table training, on the clock edge, when act:
  - Branch taken, hit: cnt saturating +1; target <= id_target_i.
  - Branch taken, miss: allocate the entry (valid=1, new tag, cnt = 2^(CNT_W-1), target) and overwrite whatever was there.
  - Branch not taken, hit: cnt saturating -1.
  - Branch not taken, miss: no change.
  - Non-branch that hits: clear valid.
- kill_q <= flush_o. The instruction in ID during the cycle after a flush is on the wrong path and is ignored: no flush, no training, no RAS change.
- If IF and ID access the same index in the same cycle, IF sees the pre-write contents.

## Timing
- Prediction and flush are combinational, zero cycles. Training and kill_q take effect at the next rising edge.
- Reset, asynchronous: all valid = 0, cnt = 0, kill_q = 0, RAS pointer = 0. Target RAM is not reset. Outputs: if_pred_taken_o = 0, and flush_o = 0 whenever id_valid_i = 0.
- Reset asserted mid-operation clears all state immediately. The first id_valid_i after reset release is always processed, never killed.
- Back-to-back mispredicts: the second is suppressed by kill_q. A third, in the cycle after that, is processed.

## Configuration
- BPU_RAS_EN defined:
  - A RAS_DEPTH circular stack is present.
  - On act && id_is_call_i: push id_pc_i+4.
  - On act && id_is_ret_i: pop, and set the entry's ret bit when allocating.
  - Call and ret together: pop, then push.
  - Overflow overwrites the oldest entry. Underflow wraps the pointer, and the stale value is corrected by the normal mispredict path.
- BPU_RAS_EN undefined:
  - No stack and no ret bit.
  - id_is_call_i and id_is_ret_i are unused.
  - The target always comes from the table.

## Structure
- Shared package bpu_pkg holds:
  - counter threshold and saturation constants;
  - entry field widths;
  - the flush_pc computation helper.
- One sub-module, bpu_ras: the stack with push/pop/top and a pointer. It is instantiated only under BPU_RAS_EN.

## Test plan
- Allocate on mispredict:
  - After reset, ID branch at 0x8000_0010, taken to 0x8000_0100, id_pred_taken_i = 0 -> flush_o = 1, flush_pc_o = 0x8000_0100.
  - Next cycle, if_pc_i = 0x8000_0010 -> taken = 1, target 0x8000_0100.
- Tag alias: with that entry live, if_pc_i = 0x8000_1010 (same idx, tag 0x10) -> if_pred_taken_o = 0.
- Hysteresis:
  - Two more taken updates take cnt to 3; one not-taken -> still predicts taken.
  - A second not-taken -> predicts not taken, cnt = 1.
- Non-branch hit and kill:
  - ID non-branch at 0x8000_0010 with id_pred_taken_i = 1 -> flush_pc_o = 0x8000_0014 and the entry is invalidated.
  - Next-cycle mispredicting branch -> flush_o = 0 and the table is unchanged.
- Target change: predicted taken to 0x8000_0100, actual 0x8000_0200 -> flush_pc_o = 0x8000_0200; the table target is updated.
- RAS (BPU_RAS_EN):
  - Call at 0x8000_0020, then ret at 0x8000_0300 is allocated.
  - Later, if_pc_i = 0x8000_0300 -> target 0x8000_0024.
  - 9 nested calls at depth 8 -> the 9th pop yields a stale value and produces a flush.
